// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine
//   RPN calculator core: DATA_W-bit operand stack of DEPTH entries with an
//   integer ALU (ADD/SUB/MUL) and an iterative unsigned restoring divider
//   (DIV/MOD). Commands arrive through a valid/ready handshake.
//
//   The top of stack is held in a register. Entries below it live in a
//   single-port RAM, stored bottom-up: with depth d, entry "second" sits
//   at RAM address d-2 and a push of the old top goes to address d-1.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  engine can accept a command (IDLE only)
//   cmd_op     opcode (0 PUSH .. 10 CLEAR, 11-15 illegal)
//   cmd_data   immediate for PUSH / APPEND
//   top        current top of stack (0 when empty)
//   depth      number of valid entries
//   empty      depth == 0
//   full       depth == DEPTH
//   error      last completed command faulted
//   err_code   0 none, 1 underflow, 2 overflow, 3 divide-by-zero
//   carry      carry of last ADD / borrow of last SUB
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | ready; 0-cycle commands and all faults complete here
// RD2      | RAM read of the second entry
// EXEC     | ALU / divider result written back to top, depth-1
// DIV_RUN  | restoring divider, one quotient bit per cycle
// POP_RD   | new top arrives from RAM (read issued at acceptance)
// SWAP_WR  | old top written to RAM, second loaded into top

module rpn_stack_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int IN_W   = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [IN_W-1:0]   cmd_data,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  depth,
  output logic              empty,
  output logic              full,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              carry
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  localparam logic [3:0] OP_PUSH   = 4'd0;
  localparam logic [3:0] OP_APPEND = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_MOD    = 4'd6;
  localparam logic [3:0] OP_POP    = 4'd7;
  localparam logic [3:0] OP_DUP    = 4'd8;
  localparam logic [3:0] OP_SWAP   = 4'd9;
  localparam logic [3:0] OP_CLEAR  = 4'd10;

  localparam logic [1:0] ERR_UNF = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_DZ  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RD2, S_EXEC, S_DIV_RUN, S_POP_RD, S_SWAP_WR
  } state_t;

  state_t state_r, state_nxt;

  logic [3:0]        op_r;
  logic [DCW-1:0]    div_cnt;
  logic [DATA_W-1:0] rem_r, quo_r;

  logic              accept;
  logic              chk_fail;
  logic [1:0]        chk_code;

  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic [DATA_W-1:0] mem [0:DEPTH-2];

  logic [DATA_W:0]   div_trial, div_diff;
  logic              div_ge;

  assign empty  = (depth == '0);
  assign full   = (depth == C_FULL);
  assign accept = cmd_valid && (state_r == S_IDLE);

  // Precondition check. DIV/MOD with too few operands reports underflow
  // before the divide-by-zero test, since there is no divisor to inspect.
  always_comb begin
    chk_fail = 1'b0;
    chk_code = 2'd0;
    case (cmd_op)
      OP_PUSH: if (full) begin chk_fail = 1'b1; chk_code = ERR_OVF; end
      OP_APPEND, OP_POP:
        if (empty) begin chk_fail = 1'b1; chk_code = ERR_UNF; end
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP:
        if (depth < C_TWO) begin chk_fail = 1'b1; chk_code = ERR_UNF; end
      OP_DIV, OP_MOD:
        if (depth < C_TWO) begin chk_fail = 1'b1; chk_code = ERR_UNF; end
        else if (top == '0) begin chk_fail = 1'b1; chk_code = ERR_DZ; end
      OP_DUP:
        if (empty) begin chk_fail = 1'b1; chk_code = ERR_UNF; end
        else if (full) begin chk_fail = 1'b1; chk_code = ERR_OVF; end
      OP_CLEAR: ;
      default: begin chk_fail = 1'b1; chk_code = ERR_UNF; end
    endcase
  end

  // Divider step: remainder stays below the divisor, so a non-negative
  // difference always fits DATA_W bits and bit DATA_W acts as the borrow.
  assign div_trial = {rem_r, ram_q[div_cnt]};
  assign div_diff  = div_trial - {1'b0, top};
  assign div_ge    = ~div_diff[DATA_W];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE:
        if (accept && !chk_fail) begin
          case (cmd_op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_SWAP: state_nxt = S_RD2;
            OP_POP:                                          state_nxt = S_POP_RD;
            default:                                         state_nxt = S_IDLE;
          endcase
        end
      S_RD2:
        if (op_r == OP_DIV || op_r == OP_MOD) state_nxt = S_DIV_RUN;
        else if (op_r == OP_SWAP)             state_nxt = S_SWAP_WR;
        else                                  state_nxt = S_EXEC;
      S_DIV_RUN:
        if (div_cnt == '0) state_nxt = S_EXEC;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs: handshake and RAM port
  always_comb begin
    cmd_ready = (state_r == S_IDLE);
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = AW'(depth - C_ONE);
    ram_wdata = top;
    case (state_r)
      S_IDLE:
        if (accept && !chk_fail) begin
          if ((cmd_op == OP_PUSH && !empty) || cmd_op == OP_DUP) ram_we = 1'b1;
          // POP issues its read at acceptance so the new top lands in one cycle
          if (cmd_op == OP_POP && depth >= C_TWO) begin
            ram_re   = 1'b1;
            ram_addr = AW'(depth - C_TWO);
          end
        end
      S_RD2: begin
        ram_re   = 1'b1;
        ram_addr = AW'(depth - C_TWO);
      end
      S_SWAP_WR: begin
        ram_we   = 1'b1;
        ram_addr = AW'(depth - C_TWO);
      end
      default: ;
    endcase
  end

  // ram_q is only reloaded on reads, so it keeps the dividend through DIV_RUN
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top      <= '0;
      depth    <= '0;
      error    <= 1'b0;
      err_code <= 2'd0;
      carry    <= 1'b0;
      op_r     <= 4'd0;
      div_cnt  <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE:
          if (accept) begin
            op_r <= cmd_op;
            if (chk_fail) begin
              error    <= 1'b1;
              err_code <= chk_code;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  top   <= {{(DATA_W-IN_W){1'b0}}, cmd_data};
                  depth <= depth + C_ONE;
                end
                OP_APPEND: top   <= {top[DATA_W-IN_W-1:0], cmd_data};
                OP_DUP:    depth <= depth + C_ONE;
                OP_CLEAR: begin
                  top   <= '0;
                  depth <= '0;
                end
                default: ;
              endcase
              if (cmd_op == OP_PUSH || cmd_op == OP_APPEND ||
                  cmd_op == OP_DUP  || cmd_op == OP_CLEAR) begin
                error    <= 1'b0;
                err_code <= 2'd0;
                carry    <= 1'b0;
              end
            end
          end
        S_RD2: begin
          div_cnt <= DCW'(DATA_W - 1);
          rem_r   <= '0;
          quo_r   <= '0;
        end
        S_DIV_RUN: begin
          rem_r   <= div_ge ? div_diff[DATA_W-1:0] : div_trial[DATA_W-1:0];
          quo_r   <= {quo_r[DATA_W-2:0], div_ge};
          div_cnt <= div_cnt - DCW'(1);
        end
        S_EXEC: begin
          case (op_r)
            OP_ADD:  {carry, top} <= {1'b0, ram_q} + {1'b0, top};
            OP_SUB:  {carry, top} <= {1'b0, ram_q} - {1'b0, top};
            OP_MUL:  begin top <= ram_q * top; carry <= 1'b0; end
            OP_DIV:  begin top <= quo_r;       carry <= 1'b0; end
            default: begin top <= rem_r;       carry <= 1'b0; end
          endcase
          depth    <= depth - C_ONE;
          error    <= 1'b0;
          err_code <= 2'd0;
        end
        S_POP_RD: begin
          top      <= (depth == C_ONE) ? '0 : ram_q;
          depth    <= depth - C_ONE;
          error    <= 1'b0;
          err_code <= 2'd0;
          carry    <= 1'b0;
        end
        S_SWAP_WR: begin
          top      <= ram_q;
          error    <= 1'b0;
          err_code <= 2'd0;
          carry    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_engine.sv
module tb_rpn_stack_engine;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int IW = 8;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_op = 4'd0;
  logic [IW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic [DW-1:0] top;
  logic [CW-1:0] depth;
  logic          empty, full, error, carry;
  logic [1:0]    err_code;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int exp_busy = 0;

  // reference model: stack as a queue, back = top of stack
  logic [DW-1:0] m_stk[$];
  logic          m_err = 1'b0;
  logic [1:0]    m_code = 2'd0;
  logic          m_carry = 1'b0;

  always #5 clk = ~clk;

  rpn_stack_engine #(.DATA_W(DW), .DEPTH(DP), .IN_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .top(top), .depth(depth),
    .empty(empty), .full(full), .error(error), .err_code(err_code), .carry(carry)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_top();
    if (m_stk.size() == 0) return '0;
    return m_stk[m_stk.size()-1];
  endfunction

  // Applies one accepted command to the model; returns busy cycles.
  function automatic int model_apply(input logic [3:0] op, input logic [IW-1:0] d);
    int n;
    int busy;
    int fc;
    logic [DW-1:0] a, b, r;
    longint unsigned wide;
    n = m_stk.size();
    busy = 0;
    fc = 0;
    b = (n > 0) ? m_stk[n-1] : '0;
    a = (n > 1) ? m_stk[n-2] : '0;
    case (op)
      4'd0: if (n == DP) fc = 2; else m_stk.push_back({{(DW-IW){1'b0}}, d});
      4'd1: if (n < 1) fc = 1; else m_stk[n-1] = {b[DW-IW-1:0], d};
      4'd2, 4'd3, 4'd4:
        if (n < 2) fc = 1;
        else begin
          if (op == 4'd2) begin
            wide = longint'(a) + longint'(b);
            r = a + b;
            m_carry = (wide > 64'hFFFF_FFFF);
          end else if (op == 4'd3) begin
            r = a - b;
            m_carry = (a < b);
          end else begin
            r = a * b;
          end
          void'(m_stk.pop_back());
          void'(m_stk.pop_back());
          m_stk.push_back(r);
          busy = 2;
        end
      4'd5, 4'd6:
        if (n < 2) fc = 1;
        else if (b == 0) fc = 3;
        else begin
          r = (op == 4'd5) ? a / b : a % b;
          void'(m_stk.pop_back());
          void'(m_stk.pop_back());
          m_stk.push_back(r);
          busy = DW + 2;
        end
      4'd7: if (n < 1) fc = 1; else begin void'(m_stk.pop_back()); busy = 1; end
      4'd8: if (n < 1) fc = 1; else if (n == DP) fc = 2; else m_stk.push_back(b);
      4'd9:
        if (n < 2) fc = 1;
        else begin
          m_stk[n-1] = a;
          m_stk[n-2] = b;
          busy = 2;
        end
      4'd10: m_stk.delete();
      default: fc = 1;
    endcase
    if (fc != 0) begin
      m_err  = 1'b1;
      m_code = 2'(fc);
      busy   = 0;
    end else begin
      m_err  = 1'b0;
      m_code = 2'd0;
      if (op != 4'd2 && op != 4'd3) m_carry = 1'b0;
    end
    return busy;
  endfunction

  // every cycle: handshake must match the model's busy prediction; when idle
  // all outputs must match the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 64'(cmd_ready), 64'(exp_busy == 0));
      if (exp_busy == 0) begin
        check("top",      64'(top),      64'(m_top()));
        check("depth",    64'(depth),    64'(m_stk.size()));
        check("empty",    64'(empty),    64'(m_stk.size() == 0));
        check("full",     64'(full),     64'(m_stk.size() == DP));
        check("error",    64'(error),    64'(m_err));
        check("err_code", 64'(err_code), 64'(m_code));
        check("carry",    64'(carry),    64'(m_carry));
      end
    end
  end

  // Presents a command at the next falling edge (possibly while the engine is
  // still busy, so the command is held) and accepts it on the predicted edge.
  task automatic do_cmd(input logic [3:0] op, input logic [IW-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (exp_busy > 0) begin
      @(posedge clk);
      exp_busy--;
    end
    @(posedge clk);
    exp_busy = model_apply(op, d);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 4'($urandom_range(0, 15));
    cmd_data  = IW'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      if (exp_busy > 0) exp_busy--;
    end
  endtask

  task automatic settle();
    while (exp_busy > 0) begin
      @(posedge clk);
      exp_busy--;
    end
    @(negedge clk);
  endtask

  task automatic pin_top(input string name, input logic [DW-1:0] exp);
    check(name, 64'(top), 64'(exp));
    check({name, "_model"}, 64'(m_top()), 64'(exp));
  endtask

  initial begin
    logic [3:0] op;
    logic [IW-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_top",   64'(top),       64'h0);
    check("rst_depth", 64'(depth),     64'h0);
    check("rst_empty", 64'(empty),     64'h1);
    check("rst_ready", 64'(cmd_ready), 64'h1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // PUSH / APPEND
    do_cmd(4'd0, 8'h12);
    do_cmd(4'd1, 8'h34);
    settle();
    pin_top("append_top", 32'h1234);
    check("append_depth", 64'(depth), 64'd1);
    check("append_err",   64'(error), 64'd0);
    do_cmd(4'd10, 8'h00);

    // SUB with and without borrow
    do_cmd(4'd0, 8'd7);
    do_cmd(4'd0, 8'd5);
    do_cmd(4'd3, 8'h00);
    settle();
    pin_top("sub1_top", 32'd2);
    check("sub1_carry", 64'(carry), 64'd0);
    do_cmd(4'd0, 8'd3);
    do_cmd(4'd0, 8'd5);
    do_cmd(4'd3, 8'h00);
    settle();
    pin_top("sub2_top", 32'hFFFF_FFFE);
    check("sub2_carry", 64'(carry), 64'd1);
    check("sub2_carry_model", 64'(m_carry), 64'd1);
    check("sub2_depth", 64'(depth), 64'd2);
    do_cmd(4'd10, 8'h00);

    // modulo, divide and divide-by-zero
    do_cmd(4'd0, 8'd100);
    do_cmd(4'd0, 8'd7);
    do_cmd(4'd6, 8'h00);
    settle();
    pin_top("mod_top", 32'd2);
    do_cmd(4'd0, 8'd100);
    do_cmd(4'd0, 8'd7);
    do_cmd(4'd5, 8'h00);
    settle();
    pin_top("div_top", 32'd14);
    do_cmd(4'd0, 8'd5);
    do_cmd(4'd0, 8'd0);
    do_cmd(4'd5, 8'h00);
    settle();
    check("dz_code",  64'(err_code), 64'd3);
    check("dz_error", 64'(error),    64'd1);
    check("dz_depth", 64'(depth),    64'd4);
    pin_top("dz_top", 32'd0);
    do_cmd(4'd10, 8'h00);

    // SWAP / POP / underflow
    do_cmd(4'd0, 8'h0A);
    do_cmd(4'd0, 8'h0B);
    do_cmd(4'd9, 8'h00);
    settle();
    pin_top("swap_top", 32'h0A);
    do_cmd(4'd7, 8'h00);
    settle();
    pin_top("pop1_top", 32'h0B);
    check("pop1_depth", 64'(depth), 64'd1);
    do_cmd(4'd7, 8'h00);
    settle();
    check("pop2_empty", 64'(empty), 64'd1);
    do_cmd(4'd7, 8'h00);
    settle();
    check("pop3_code",  64'(err_code), 64'd1);
    check("pop3_depth", 64'(depth),    64'd0);

    // full / overflow / CLEAR
    for (int i = 1; i <= 4; i++) do_cmd(4'd0, 8'(i));
    settle();
    check("full_flag", 64'(full), 64'd1);
    do_cmd(4'd0, 8'd5);
    settle();
    check("ovf_code", 64'(err_code), 64'd2);
    pin_top("ovf_top", 32'd4);
    do_cmd(4'd10, 8'h00);
    settle();
    check("clear_depth", 64'(depth), 64'd0);
    check("clear_error", 64'(error), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd0;
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      do_cmd(op, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    settle();

    // reset in the middle of a DIV
    do_cmd(4'd10, 8'h00);
    do_cmd(4'd0, 8'd100);
    do_cmd(4'd0, 8'd7);
    do_cmd(4'd5, 8'h00);
    repeat (9) begin
      @(posedge clk);
      exp_busy--;
    end
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_top",   64'(top),       64'h0);
    check("mid_rst_depth", 64'(depth),     64'h0);
    check("mid_rst_empty", 64'(empty),     64'h1);
    check("mid_rst_full",  64'(full),      64'h0);
    check("mid_rst_error", 64'(error),     64'h0);
    check("mid_rst_code",  64'(err_code),  64'h0);
    check("mid_rst_carry", 64'(carry),     64'h0);
    check("mid_rst_ready", 64'(cmd_ready), 64'h1);
    m_stk.delete();
    m_err = 1'b0;
    m_code = 2'd0;
    m_carry = 1'b0;
    exp_busy = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_cmd(4'd0, 8'd1);
    settle();
    pin_top("post_rst_top", 32'd1);
    check("post_rst_depth", 64'(depth), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
- Parametrised successor to the push-button RPN calculator core: a DATA_W-bit, DEPTH-entry operand stack with an integer ALU and an iterative divider.
- Commands arrive through a valid/ready handshake instead of raw buttons, so the core can be driven by the button debouncer front end or by a UART command decoder.
- Adds MOD, a working SWAP, CLEAR, error codes, a carry/borrow flag and a FULL output.

Parameters:
DATA_W, 32, operand/result width (>=8, even)
DEPTH, 512, stack entries (power of two, >=4)
IN_W, 8, width of immediate data per PUSH/APPEND
CNT_W, $clog2(DEPTH)+1, width of depth count

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command this cycle
cmd_op  in  4  opcode
cmd_data  in  IN_W  immediate for PUSH/APPEND
top  out  DATA_W  current top of stack (0 when empty)
depth  out  CNT_W  number of valid entries
empty  out  1  depth==0
full  out  1  depth==DEPTH
error  out  1  last completed command faulted (sticky until next successful command or CLEAR)
err_code  out  2  0 none, 1 underflow, 2 overflow, 3 divide-by-zero
carry  out  1  carry out of last ADD / borrow of last SUB; cleared by any other successful op

Behaviour:
- Reset (async, rst_n low): depth=0, top=0, empty=1, full=0, error=0, err_code=0, carry=0, cmd_ready=1, FSM=IDLE, divider aborted. The RAM contents are don't-care.
- Handshake: a command is accepted on a rising edge with cmd_valid&&cmd_ready. cmd_ready is 1 only in IDLE. Commands arriving while busy are held by the sender.
- Storage: top kept in a register; entries 1..depth-1 live in a single-port RAM (DEPTH-1 words). Outputs update on the edge that completes the command.
- Opcodes, with required depth precondition and busy cycles after acceptance:
  - 0 PUSH (<DEPTH, 0): old top written to RAM; top={0,cmd_data}.
  - 1 APPEND (>=1, 0): top={top[DATA_W-IN_W-1:0],cmd_data}.
  - 2 ADD, 3 SUB, 4 MUL (>=2, 2): cycle 1 reads second entry (a); cycle 2 sets top=a op top (SUB is a-top), low DATA_W bits, and decrements depth.
  - 5 DIV, 6 MOD (>=2 and top!=0, DATA_W+2): cycle 1 reads a; an unsigned restoring divider then runs one bit per cycle; the last cycle sets top=a/top or a%top and decrements depth.
  - 7 POP (>=1, 1): depth-1. The new top is read from RAM, or is 0 if the stack becomes empty.
  - 8 DUP (>=1 and <DEPTH, 0): top pushed to RAM; depth+1.
  - 9 SWAP (>=2, 2): exchanges top and second.
  - 10 CLEAR (any, 0): depth=0, top=0, error=0, carry=0.
  - 11-15: treated as a failed command with err_code=1, stack unchanged.
- Failed precondition: the stack and carry are unchanged, error=1, and err_code is set. Priority is div-by-zero over underflow over overflow, with one exception: DIV/MOD with depth<2 reports underflow. Completes in 0 busy cycles.
- Successful command: error=0, err_code=0.
- FSM states: IDLE, RD2 (RAM read of second), EXEC (ALU writeback), DIV_RUN, POP_RD, SWAP_WR. Every state returns to IDLE.
- Reset asserted mid-DIV or mid-SWAP: the operation is aborted; no partial write is visible after reset.

Test Plan:
- Reset, PUSH 0x12, APPEND 0x34 -> top=0x1234, depth=1, cmd_ready high throughout, error=0.
- Push 7,5 (DATA_W=32); SUB -> top=2, carry=0; push 3,5 SUB -> top=0xFFFFFFFE, carry=1, depth=2. Check cmd_ready low exactly 2 cycles per SUB.
- Push 100,7; MOD -> top=2 after 34 busy cycles. Push 100,7, DIV -> top=14. Push 5,0, DIV -> error=1, err_code=3, depth and top (0) unchanged.
- Push 0xA,0xB; SWAP -> top=0xA; POP -> top=0xB, depth=1. POP -> empty=1, top=0. POP -> err_code=1, depth stays 0.
- DEPTH=4: 4 PUSHes -> full=1. 5th PUSH -> err_code=2, top unchanged. CLEAR -> depth=0, error=0.
- Assert rst_n low during cycle 10 of a DIV -> all outputs at reset values immediately, cmd_ready=1 after release; a following PUSH 1 gives depth=1, top=1.
